// File: rtl/soc_ctrl_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : soc_ctrl_mailbox
// Brief    : Control/status slave on the core data bus: sticky exit code,
//            first-word-fall-through character FIFO and a saturating timer.
// Revision : 1.0 - initial release
// ============================================================================
module soc_ctrl_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [31:0]      addr_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [7:0]       char_o,
    output logic             char_valid_o,
    input  logic             char_ready_i,
    output logic             exit_valid_o,
    output logic [31:0]      exit_code_o,
    output logic             timer_running_o,
    output logic [CNT_W-1:0] cycles_o
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

    localparam logic [4:0] c_off_exit   = 5'h00;
    localparam logic [4:0] c_off_putc   = 5'h04;
    localparam logic [4:0] c_off_tctrl  = 5'h08;
    localparam logic [4:0] c_off_cycles = 5'h0C;
    localparam logic [4:0] c_off_status = 5'h10;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic                r_exit_valid;
    logic [31:0]         r_exit_code;
    logic                r_running;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_lvl_w-1:0]  r_level;
    logic [7:0]          r_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Decode and handshake
    // ------------------------------------------------------------------
    logic        w_sel;
    logic [4:0]  w_off;
    logic        w_full;
    logic        w_empty;
    logic        w_gnt;
    logic        w_unmapped;
    logic        w_push;
    logic        w_pop;
    logic        w_exit_wr;
    logic        w_timer_wr;
    logic [31:0] w_rd_data;
    logic [31:0] w_cycles32;
    logic [7:0]  w_level8;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_sel   = req_i && (addr_i[31:24] == BASE_ADDR[31:24]);
    assign w_off   = addr_i[4:0];
    assign w_full  = (r_level == c_full_lvl);
    assign w_empty = (r_level == '0);

    // Full comes from registered state: a same-cycle pop does not unblock a push.
    assign w_gnt = w_sel && !(we_i && (w_off == c_off_putc) && w_full);

    assign w_unmapped = (w_off != c_off_exit)   && (w_off != c_off_putc)  &&
                        (w_off != c_off_tctrl)  && (w_off != c_off_cycles) &&
                        (w_off != c_off_status);

    assign w_push     = w_gnt && we_i && (w_off == c_off_putc);
    assign w_pop      = !w_empty && char_ready_i;
    assign w_exit_wr  = w_gnt && we_i && (w_off == c_off_exit);
    assign w_timer_wr = w_gnt && we_i && (w_off == c_off_tctrl);

    assign w_unused = ^{be_i, addr_i[23:5]};

    generate
        if (CNT_W >= 32) begin : g_cyc_trunc
            assign w_cycles32 = r_cnt[31:0];
        end else begin : g_cyc_ext
            assign w_cycles32 = {{(32-CNT_W){1'b0}}, r_cnt};
        end
    endgenerate

    generate
        if (c_lvl_w >= 8) begin : g_lvl_trunc
            assign w_level8 = r_level[7:0];
        end else begin : g_lvl_ext
            assign w_level8 = {{(8-c_lvl_w){1'b0}}, r_level};
        end
    endgenerate

    assign w_status = {16'h0000, w_level8, 6'b000000, w_full, r_exit_valid};

    always_comb begin
        w_rd_data = 32'h0000_0000;
        if (!we_i) begin
            case (w_off)
                c_off_exit:   w_rd_data = r_exit_code;
                c_off_tctrl:  w_rd_data = {31'h0, r_running};
                c_off_cycles: w_rd_data = w_cycles32;
                c_off_status: w_rd_data = w_status;
                default:      w_rd_data = 32'h0000_0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response channel: one rvalid pulse per grant, one cycle later
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0000_0000;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_rdata  <= w_gnt ? w_rd_data : 32'h0000_0000;
            r_err    <= w_gnt && w_unmapped;
        end
    end

    // ------------------------------------------------------------------
    // Exit code: first write wins, later writes are ignored
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exit_valid <= 1'b0;
            r_exit_code  <= 32'h0000_0000;
        end else if (w_exit_wr && !r_exit_valid) begin
            r_exit_valid <= 1'b1;
            r_exit_code  <= wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Cycle timer: restart beats increment, stop holds the count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
            r_cnt     <= '0;
        end else if (w_timer_wr) begin
            if (wdata_i[0]) begin
                r_running <= 1'b1;
                r_cnt     <= '0;
            end else begin
                r_running <= 1'b0;
            end
        end else if (r_running && (r_cnt != '1)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; emptiness masks stale entries on char_o.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt_o           = w_gnt;
    assign rvalid_o        = r_rvalid;
    assign rdata_o         = r_rdata;
    assign err_o           = r_err;
    assign char_valid_o    = !w_empty;
    assign char_o          = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign exit_valid_o    = r_exit_valid;
    assign exit_code_o     = r_exit_code;
    assign timer_running_o = r_running;
    assign cycles_o        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_soc_ctrl_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_ctrl_mailbox
// Brief    : Directed self-checking bench for soc_ctrl_mailbox.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_ctrl_mailbox;

    localparam logic [31:0] c_base = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  chr;
    logic        chr_valid;
    logic        chr_ready;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        running;
    logic [31:0] cycles;

    // Narrow-counter instance on the same bus, used for saturation
    logic        gnt_s;
    logic        rvalid_s;
    logic [31:0] rdata_s;
    logic        err_s;
    logic [7:0]  chr_s;
    logic        chr_valid_s;
    logic        exit_valid_s;
    logic [31:0] exit_code_s;
    logic        running_s;
    logic [3:0]  cycles_s;

    int n_checks = 0;
    int n_fail   = 0;

    soc_ctrl_mailbox #(.BASE_ADDR(c_base), .FIFO_DEPTH(8), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
        .err_o(err), .char_o(chr), .char_valid_o(chr_valid), .char_ready_i(chr_ready),
        .exit_valid_o(exit_valid), .exit_code_o(exit_code),
        .timer_running_o(running), .cycles_o(cycles)
    );

    soc_ctrl_mailbox #(.BASE_ADDR(c_base), .FIFO_DEPTH(2), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt_s), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_s), .rdata_o(rdata_s),
        .err_o(err_s), .char_o(chr_s), .char_valid_o(chr_valid_s), .char_ready_i(chr_ready),
        .exit_valid_o(exit_valid_s), .exit_code_o(exit_code_s),
        .timer_running_o(running_s), .cycles_o(cycles_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the response cycle.
    task automatic bus_xfer(input logic wr, input logic [7:0] off, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
        int waited;
        waited = 0;
        req   = 1'b1;
        we    = wr;
        addr  = c_base | {24'h0, off};
        wdata = wd;
        #1;
        while (!gnt && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!gnt) begin
            check_val("bus_grant_timeout", 32'(gnt), 32'd1);
            req = 1'b0;
            we  = 1'b0;
            rd  = 32'h0;
            er  = 1'b0;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            req = 1'b0;
            we  = 1'b0;
            check_val("rvalid_after_grant", 32'(rvalid), 32'd1);
            rd = rdata;
            er = err;
        end
    endtask

    task automatic bus_wr(input logic [7:0] off, input logic [31:0] wd);
        logic [31:0] rd;
        logic        er;
        bus_xfer(1'b1, off, wd, rd, er);
    endtask

    task automatic bus_rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        bus_xfer(1'b0, off, 32'h0, rd, er);
        check_val(tag, rd, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        addr      = 32'h0;
        we        = 1'b0;
        be        = 4'hF;
        wdata     = 32'h0;
        chr_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_gnt",        32'(gnt),        32'd0);
        check_val("rst_rvalid",     32'(rvalid),     32'd0);
        check_val("rst_rdata",      rdata,           32'd0);
        check_val("rst_err",        32'(err),        32'd0);
        check_val("rst_char_valid", 32'(chr_valid),  32'd0);
        check_val("rst_char",       32'(chr),        32'd0);
        check_val("rst_exit_valid", 32'(exit_valid), 32'd0);
        check_val("rst_exit_code",  exit_code,       32'd0);
        check_val("rst_running",    32'(running),    32'd0);
        check_val("rst_cycles",     cycles,          32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Outside the window: no grant, no response
        req = 1'b1; we = 1'b1; addr = 32'h9000_0004; wdata = 32'h41;
        #1;
        check_val("unsel_gnt", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        check_val("unsel_rvalid",     32'(rvalid),    32'd0);
        check_val("unsel_char_valid", 32'(chr_valid), 32'd0);

        // "Hi\n" with the sink always ready
        chr_ready = 1'b1;
        bus_wr(8'h04, 32'h48);
        check_val("hi_valid0", 32'(chr_valid), 32'd1);
        check_val("hi_char0",  32'(chr),       32'h48);
        bus_wr(8'h04, 32'h69);
        check_val("hi_char1",  32'(chr),       32'h69);
        bus_wr(8'h04, 32'h0A);
        check_val("hi_char2",  32'(chr),       32'h0A);
        @(posedge clk); #1;
        check_val("hi_empty",  32'(chr_valid), 32'd0);

        // Fill to depth with the sink stalled, then unblock with one pop
        chr_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_wr(8'h04, 32'h30 + 32'(i));
        req = 1'b1; we = 1'b1; addr = c_base | 32'h04; wdata = 32'h38;
        #1;
        check_val("full_gnt_blocked", 32'(gnt), 32'd0);
        req = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        bus_rd_chk("full_status", 8'h10, 32'h0000_0802);
        check_val("full_head", 32'(chr), 32'h30);
        req = 1'b1; we = 1'b1; addr = c_base | 32'h04; wdata = 32'h38; chr_ready = 1'b1;
        #1;
        check_val("full_gnt_same_cycle_pop", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        chr_ready = 1'b0;
        check_val("full_gnt_after_pop", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        check_val("full_9th_rvalid", 32'(rvalid), 32'd1);
        chr_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_val($sformatf("drain_%0d", i), 32'(chr), 32'h30 + 32'(i));
            @(posedge clk); #1;
        end
        check_val("drain_empty", 32'(chr_valid), 32'd0);
        chr_ready = 1'b0;

        // Exit code is sticky on the first write
        check_val("exit_pre", 32'(exit_valid), 32'd0);
        bus_wr(8'h00, 32'h0000_0000);
        check_val("exit_valid_set", 32'(exit_valid), 32'd1);
        check_val("exit_code0",     exit_code,        32'h0);
        bus_wr(8'h00, 32'hDEAD_BEEF);
        check_val("exit_code_kept", exit_code,        32'h0);
        bus_rd_chk("exit_read", 8'h00, 32'h0000_0000);

        // Timer: restart beats increment, then a 100-cycle window
        bus_wr(8'h08, 32'h1);
        check_val("tmr_running", 32'(running), 32'd1);
        check_val("tmr_start0",  cycles,       32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_val("tmr_count5",  cycles,       32'd5);
        bus_wr(8'h08, 32'h1);
        check_val("tmr_restart0", cycles,      32'd0);
        repeat (100) @(posedge clk);
        #1;
        bus_wr(8'h08, 32'h0);
        check_val("tmr_stopped", 32'(running), 32'd0);
        check_val("tmr_cycles_o", cycles,      32'd100);
        bus_rd_chk("tmr_read_cycles", 8'h0C, 32'd100);
        repeat (10) @(posedge clk);
        #1;
        bus_rd_chk("tmr_read_held", 8'h0C, 32'd100);
        bus_rd_chk("tmr_read_ctrl", 8'h08, 32'd0);
        check_val("tmr_saturate", 32'(cycles_s), 32'hF);

        // Unmapped offset then STATUS, back to back
        req = 1'b1; we = 1'b0; addr = c_base | 32'h14;
        #1;
        check_val("b2b_gnt0", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        addr = c_base | 32'h10;
        check_val("b2b_rvalid0", 32'(rvalid), 32'd1);
        check_val("b2b_err0",    32'(err),    32'd1);
        check_val("b2b_rdata0",  rdata,       32'd0);
        check_val("b2b_gnt1",    32'(gnt),    32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        check_val("b2b_rvalid1", 32'(rvalid), 32'd1);
        check_val("b2b_err1",    32'(err),    32'd0);
        check_val("b2b_rdata1",  rdata,       32'h0000_0001);
        @(posedge clk); #1;
        check_val("b2b_rvalid_end", 32'(rvalid), 32'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) bus_wr(8'h04, 32'h61 + 32'(i));
        bus_wr(8'h08, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_queued", 32'(chr_valid), 32'd1);
        req = 1'b1; we = 1'b0; addr = c_base | 32'h10;
        @(posedge clk); #2;
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mid_rvalid",     32'(rvalid),     32'd0);
        check_val("mid_char_valid", 32'(chr_valid),  32'd0);
        check_val("mid_running",    32'(running),    32'd0);
        check_val("mid_exit_valid", 32'(exit_valid), 32'd0);
        check_val("mid_cycles",     cycles,          32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        bus_rd_chk("mid_status_after", 8'h10, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/soc_ctrl_mailbox.md
Name: soc_ctrl_mailbox

Overview:
Memory-mapped control and status slave on the cv32e40p data bus. It decodes the 0x80xx_xxxx window and handles the exit-code register, the character output stream, and a cycle timer. It replaces the inline address decode and one-cycle rvalid glue in the RedMulE system bench, and it feeds a character sink and the end-of-test logic. It uses the same req/gnt/rvalid handshake as the data port of the core.

Parameters:
BASE_ADDR, 32'h8000_0000, window base; only bits [31:24] are compared.
FIFO_DEPTH, 8, character FIFO entries; must be a power of two, at least 2.
CNT_W, 32, cycle counter width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req_i  in  1  core data request
gnt_o  out  1  grant for the current request
addr_i  in  32  byte address
we_i  in  1  write enable (1 = write)
be_i  in  4  byte enables (ignored by this block)
wdata_i  in  32  write data
rvalid_o  out  1  response valid
rdata_o  out  32  read data; 0 for writes
err_o  out  1  unmapped-offset flag, qualified by rvalid_o
char_o  out  8  output character
char_valid_o  out  1  character available
char_ready_i  in  1  sink accepts character
exit_valid_o  out  1  exit code has been written (sticky)
exit_code_o  out  32  latched exit code
timer_running_o  out  1  cycle counter running
cycles_o  out  CNT_W  current counter value

Behaviour:
- Clock and reset: clk; rst_n is asynchronous, active-low. All state is cleared on reset.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, char_valid_o=0, char_o=0, exit_valid_o=0, exit_code_o=0, timer_running_o=0, cycles_o=0. FIFO is empty.
- Select: sel = req_i & (addr_i[31:24]==BASE_ADDR[31:24]). If sel=0, gnt_o=0 and no state changes.
- Grant (combinational): gnt_o = sel & ~(we_i & offset==0x04 & fifo_full). The full flag is taken from registered state, so a pop in the same cycle does not unblock the push. A write to PUTC while the FIFO is full is stalled until there is space.
- Response: when a request is granted in cycle N, rvalid_o=1 in cycle N+1 for exactly one cycle. rdata_o and err_o are valid in that cycle. Back-to-back grants give back-to-back rvalid pulses.
- Register map, offset = addr_i[4:0]:
  - 0x00 EXIT. Write: if exit_valid_o=0, exit_code_o<=wdata_i and exit_valid_o<=1. Later writes are ignored. Read: returns exit_code_o.
  - 0x04 PUTC. Write: push wdata_i[7:0] into the FIFO. Read: returns 0.
  - 0x08 TIMER_CTRL. Write with wdata_i[0]=1: counter<=0 and running<=1. Write with wdata_i[0]=0: running<=0 and the count is held. Read: returns {31'b0, running}.
  - 0x0C CYCLES. Read: counter value in the grant cycle, zero-extended or truncated to 32 bits. Write: ignored.
  - 0x10 STATUS. Read: {16'b0, fifo_level[7:0], 6'b0, fifo_full, exit_valid}. Write: ignored.
  - Any other offset: granted, rdata_o=0, err_o=1 together with rvalid_o. No state changes.
- Character FIFO:
  - Output is first-word-fall-through: char_valid_o = ~empty, and char_o = head entry.
  - A pop happens when char_valid_o & char_ready_i.
  - A push into an empty FIFO gives char_valid_o=1 in the next cycle.
  - Simultaneous push and pop with 0 < level < FIFO_DEPTH leaves the level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH.
- Cycle counter:
  - Increments by 1 every cycle while running, and saturates at all-ones.
  - A start write in the same cycle as an increment wins: counter=0 the next cycle.
  - cycles_o is the registered counter value.
- Reset mid-operation: FIFO contents are lost, exit is cleared, and the timer stops. A pending response is dropped (rvalid_o=0).

Test Plan:
- Write 0x0000_0000 to EXIT, then write 0xDEAD_BEEF to EXIT, then read EXIT -> exit_valid_o=1 one cycle after the first grant; exit_code_o stays 0; the read returns 0x0000_0000.
- Write "Hi\n" (0x48, 0x69, 0x0A) to PUTC with char_ready_i=1 -> char_o outputs 0x48, 0x69, 0x0A in order, each one cycle after its grant; FIFO is empty afterwards.
- Hold char_ready_i=0 and write 9 characters with FIFO_DEPTH=8 -> the 9th request sees gnt_o=0; STATUS reads 0x0000_0802; after one pop, the 9th write is granted.
- Write 1 to TIMER_CTRL, wait 100 cycles, write 0, then read CYCLES -> read returns the number of cycles between the two grants (100 ± the fixed write-to-write distance); a read 10 cycles later returns the same value.
- Read offset 0x14, then read 0x10 back-to-back -> two consecutive rvalid_o pulses; err_o=1 on the first only; rdata_o=0 on the first.
- Assert rst_n=0 with 3 characters queued and the timer running -> char_valid_o, timer_running_o, exit_valid_o and cycles_o are 0 immediately (asynchronously); after reset release, STATUS reads 0.
